// File: rtl/cacheline_adapter.sv
// Cacheline adapter: one LINE_WIDTH read/write from the arbiter becomes a fixed BEATS-beat memory burst.
// Request-to-burst is 1 cycle and line_resp follows the last pmem_resp by 1 cycle. Memory stalls by withholding pmem_resp.
module cacheline_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [31:0]           pmem_address,
    output logic [BEAT_WIDTH-1:0] pmem_wdata,
    input  logic [BEAT_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [LINE_WIDTH-1:0] rbuf_q, rbuf_d;
    logic                  last_beat;
    int                    beat_lsb;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign beat_lsb  = int'(cnt_q) * BEAT_WIDTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Read takes priority if the arbiter ever raises both requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (line_read) begin
                    addr_d  = line_address & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = READ;
                end else if (line_write) begin
                    addr_d  = line_address & ALIGN_MASK;
                    wbuf_d  = line_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (pmem_resp) begin
                    rbuf_d[beat_lsb +: BEAT_WIDTH] = pmem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come only from registered state so memory inputs never reach them combinationally.
    always_comb begin
        pmem_read    = (state_q == READ);
        pmem_write   = (state_q == WRITE);
        pmem_address = '0;
        pmem_wdata   = '0;
        line_resp    = (state_q == DONE);
        line_rdata   = rbuf_q;
        if (state_q == READ || state_q == WRITE) begin
            pmem_address = addr_q;
        end
        if (state_q == WRITE) begin
            pmem_wdata = wbuf_q[beat_lsb +: BEAT_WIDTH];
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: a driver issues transactions and plays memory,
// a negedge monitor pops the expected completion from a scoreboard queue on each line_resp.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    typedef struct {
        bit           is_read;
        logic [255:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 0;

    cacheline_adapter #(.LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every line_resp must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!done && line_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_line_resp", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_read) chk("line_rdata", line_rdata, e.rdata);
                else           chk("write_resp", {255'd0, line_resp}, 256'd1);
            end
        end
    end

    task automatic check_beat(input bit rd, input logic [31:0] exp_addr,
                              input logic [255:0] wline, input int i);
        chk("pmem_read",    {255'd0, pmem_read},  {255'd0, rd});
        chk("pmem_write",   {255'd0, pmem_write}, {255'd0, !rd});
        chk("pmem_address", {224'd0, pmem_address}, {224'd0, exp_addr});
        if (!rd) chk("pmem_wdata", {192'd0, pmem_wdata}, {192'd0, wline[i*64 +: 64]});
        chk("line_resp_low", {255'd0, line_resp}, 256'd0);
    endtask

    // Called at a negedge with the DUT idle. Returns at a negedge with the DUT idle again.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] exp_addr, input logic [255:0] wline,
                       input logic [255:0] rline, input int gap, input bit perturb);
        exp_t e;
        e.is_read = rd;
        e.rdata   = rline;
        exp_q.push_back(e);
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wline;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                pmem_resp = 1'b0;
                check_beat(rd, exp_addr, wline, i);
                @(negedge clk);
            end
            pmem_resp  = 1'b1;
            pmem_rdata = rline[i*64 +: 64];
            check_beat(rd, exp_addr, wline, i);
            if (perturb && i == 1) begin
                line_address = ~addr;
                line_wdata   = ~wline;
                if (rd) line_read = 1'b0;
            end
            @(negedge clk);
        end
        pmem_resp  = 1'b0;
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("line_resp_latency", {255'd0, line_resp}, 256'd1);
        line_read  = 1'b0;
        line_write = 1'b0;
        @(negedge clk);
        chk("line_resp_one_cycle", {255'd0, line_resp}, 256'd0);
        chk("idle_pmem_read",  {255'd0, pmem_read},  256'd0);
        chk("idle_pmem_write", {255'd0, pmem_write}, 256'd0);
        chk("idle_pmem_address", {224'd0, pmem_address}, 256'd0);
    endtask

    logic [255:0] rd_line, wr_line, sim_line, fresh_line, zero_line;

    initial begin
        rd_line    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wr_line    = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        sim_line   = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                      64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        fresh_line = {64'h8888_0000_0000_0004, 64'h7777_0000_0000_0003,
                      64'h6666_0000_0000_0002, 64'h5555_0000_0000_0001};
        zero_line  = '0;

        rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_address = '0;
        line_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_line_resp",    {255'd0, line_resp},  256'd0);
        chk("rst_pmem_read",    {255'd0, pmem_read},  256'd0);
        chk("rst_pmem_write",   {255'd0, pmem_write}, 256'd0);
        chk("rst_pmem_address", {224'd0, pmem_address}, 256'd0);
        chk("rst_pmem_wdata",   {192'd0, pmem_wdata}, 256'd0);
        chk("rst_line_rdata",   line_rdata, zero_line);
        rst = 1'b0;
        @(negedge clk);

        // Contiguous read: minimum latency.
        txn(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5660, zero_line, rd_line, 0, 1'b0);
        chk("rdata_held_after_resp", line_rdata, rd_line);

        // Gapped write, two idle cycles before each beat.
        txn(1'b0, 1'b1, 32'h8000_003F, 32'h8000_0020, wr_line, zero_line, 2, 1'b0);

        // Input changes mid-write and request dropped mid-read.
        txn(1'b0, 1'b1, 32'h0000_1001, 32'h0000_1000, wr_line, zero_line, 1, 1'b1);
        txn(1'b1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F000, zero_line, sim_line, 1, 1'b1);

        // Both requests raised: read wins.
        txn(1'b1, 1'b1, 32'h0000_00E0, 32'h0000_00E0, wr_line, rd_line, 0, 1'b0);

        // Stray memory responses while idle.
        pmem_resp = 1'b1; pmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk("stray_pmem_read",  {255'd0, pmem_read},  256'd0);
            chk("stray_pmem_write", {255'd0, pmem_write}, 256'd0);
            chk("stray_line_rdata", line_rdata, rd_line);
        end
        pmem_resp = 1'b0;
        @(negedge clk);

        // Reset after two read beats: no completion, then a clean read.
        line_read = 1'b1; line_address = 32'h0000_4000;
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = 64'h9999_9999_9999_9999;
        @(negedge clk);
        pmem_rdata = 64'hAAAA_0000_AAAA_0000;
        @(negedge clk);
        pmem_resp = 1'b0; rst = 1'b1; line_read = 1'b0;
        @(negedge clk);
        chk("midrst_pmem_read",    {255'd0, pmem_read},  256'd0);
        chk("midrst_pmem_address", {224'd0, pmem_address}, 256'd0);
        chk("midrst_line_resp",    {255'd0, line_resp},  256'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_pmem_read", {255'd0, pmem_read}, 256'd0);
        txn(1'b1, 1'b0, 32'h0000_4010, 32'h0000_4000, zero_line, fresh_line, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
